// File: rtl/fp_wb_pkg.sv
// Shared types for the FP writeback unit: result tag layout, exception flags, buffered entry.
package fp_wb_pkg;

  localparam int WB_DATA_W = 32;

  // Bit positions inside the {NV,DZ,OF,UF,NX} status vector
  localparam int FLAG_NX = 0;
  localparam int FLAG_UF = 1;
  localparam int FLAG_OF = 2;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_NV = 4;

  typedef logic [4:0] fflags_t;

  typedef struct packed {
    logic       int_dest;
    logic [4:0] rd;
  } wb_tag_t;

  typedef struct packed {
    logic [WB_DATA_W-1:0] data;
    fflags_t              status;
    wb_tag_t              tag;
  } wb_entry_t;

endpackage

// File: rtl/fp_wb_fifo.sv
// Generic synchronous FIFO with full/empty/count; flush empties it on the next edge.
module fp_wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  // Pointers are exactly log2(DEPTH) bits so they wrap without extra logic
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/fp_wb_unit.sv
// Buffers fpnew results and retires them to the FP regfile or integer writeback; tracks pending
// FP destinations and sticky fflags. Optional same-cycle bypass via FP_WB_BYPASS_EN.
module fp_wb_unit
  import fp_wb_pkg::*;
#(
  parameter int DATAWIDTH  = WB_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = $bits(wb_tag_t)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 issue_valid_i,
  input  logic [TAG_W-1:0]     issue_tag_i,
  input  logic                 res_valid_i,
  output logic                 res_ready_o,
  input  logic [DATAWIDTH-1:0] res_data_i,
  input  logic [4:0]           res_status_i,
  input  logic [TAG_W-1:0]     res_tag_i,
  output logic                 fwb_we_o,
  output logic [4:0]           fwb_addr_o,
  output logic [DATAWIDTH-1:0] fwb_data_o,
  output logic                 iwb_valid_o,
  input  logic                 iwb_ready_i,
  output logic [4:0]           iwb_addr_o,
  output logic [DATAWIDTH-1:0] iwb_data_o,
  output logic [4:0]           fflags_o,
  input  logic                 fflags_clr_i,
  output logic [31:0]          pending_o
);
  localparam int EW = DATAWIDTH + 5 + TAG_W;
  localparam int CW = $clog2(FIFO_DEPTH+1);

  logic [EW-1:0]        head_entry;
  logic                 fifo_full, fifo_empty, push, pop;
  logic [CW-1:0]        fifo_count;
  wb_tag_t              head_tag, issue_tag;
  logic                 ret_valid, ret_int, ret_pop, bypass;
  logic [4:0]           ret_rd;
  logic [DATAWIDTH-1:0] ret_data;
  fflags_t              ret_status;
  logic [31:0]          set_mask, clr_mask;

  assign head_tag  = wb_tag_t'(head_entry[TAG_W-1:0]);
  assign issue_tag = wb_tag_t'(issue_tag_i);

  fp_wb_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .flush (flush_i),
    .push  (push),
    .din   ({res_data_i, res_status_i, res_tag_i}),
    .pop   (pop),
    .dout  (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef FP_WB_BYPASS_EN
  wb_tag_t res_tag;
  assign res_tag = wb_tag_t'(res_tag_i);
`endif

  // Retire candidate: buffered head first; an incoming result only when the buffer is empty
  always_comb begin
    bypass     = 1'b0;
    ret_valid  = 1'b0;
    ret_int    = 1'b0;
    ret_rd     = '0;
    ret_data   = '0;
    ret_status = '0;
    if (!flush_i && !fifo_empty) begin
      ret_valid  = 1'b1;
      ret_int    = head_tag.int_dest;
      ret_rd     = head_tag.rd;
      ret_data   = head_entry[EW-1 -: DATAWIDTH];
      ret_status = head_entry[TAG_W +: 5];
    end
`ifdef FP_WB_BYPASS_EN
    else if (!flush_i && !rst_i && res_valid_i && (!res_tag.int_dest || iwb_ready_i)) begin
      bypass     = 1'b1;
      ret_valid  = 1'b1;
      ret_int    = res_tag.int_dest;
      ret_rd     = res_tag.rd;
      ret_data   = res_data_i;
      ret_status = res_status_i;
    end
`endif
  end

  assign ret_pop     = ret_valid & (~ret_int | iwb_ready_i);
  assign pop         = ret_pop & ~bypass;
  assign res_ready_o = ~fifo_full | pop;
  assign push        = res_valid_i & res_ready_o & ~flush_i & ~bypass;

  assign fwb_we_o    = ret_valid & ~ret_int;
  assign fwb_addr_o  = fwb_we_o ? ret_rd : '0;
  assign fwb_data_o  = fwb_we_o ? ret_data : '0;
  assign iwb_valid_o = ret_valid & ret_int;
  assign iwb_addr_o  = iwb_valid_o ? ret_rd : '0;
  assign iwb_data_o  = iwb_valid_o ? ret_data : '0;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_valid_i && !issue_tag.int_dest) set_mask[issue_tag.rd] = 1'b1;
    if (ret_pop && !ret_int)                  clr_mask[ret_rd]        = 1'b1;
  end

  // Set is applied after clear so a re-issue in the retire cycle keeps the bit
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        pending_o <= '0;
    else if (flush_i) pending_o <= '0;
    else              pending_o <= (pending_o & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)             fflags_o <= '0;
    else if (fflags_clr_i) fflags_o <= ret_pop ? ret_status : '0;
    else if (ret_pop)      fflags_o <= fflags_o | ret_status;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (fifo_full == (fifo_count == CW'(FIFO_DEPTH)));
      if (issue_valid_i && !flush_i && !issue_tag.int_dest)
        assert (!pending_o[issue_tag.rd] || clr_mask[issue_tag.rd]);
    end
  end

endmodule

// File: tb/tb_fp_wb_unit.sv
// Directed scenarios followed by randomized traffic checked against a queue-based reference model.
module tb_fp_wb_unit;
  localparam int W = 43;  // {data[31:0], status[4:0], tag[5:0]}

  logic        clk = 1'b0;
  logic        rst_i, flush_i, issue_valid_i, res_valid_i, res_ready_o;
  logic [5:0]  issue_tag_i, res_tag_i;
  logic [31:0] res_data_i, fwb_data_o, iwb_data_o;
  logic [4:0]  res_status_i, fwb_addr_o, iwb_addr_o, fflags_o;
  logic        fwb_we_o, iwb_valid_o, iwb_ready_i, fflags_clr_i;
  logic [31:0] pending_o;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q[$];
  logic [31:0]  m_pend;
  logic [4:0]   m_flags;

  fp_wb_unit dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_tag_i(issue_tag_i),
    .res_valid_i(res_valid_i), .res_ready_o(res_ready_o), .res_data_i(res_data_i),
    .res_status_i(res_status_i), .res_tag_i(res_tag_i),
    .fwb_we_o(fwb_we_o), .fwb_addr_o(fwb_addr_o), .fwb_data_o(fwb_data_o),
    .iwb_valid_o(iwb_valid_o), .iwb_ready_i(iwb_ready_i), .iwb_addr_o(iwb_addr_o),
    .iwb_data_o(iwb_data_o), .fflags_o(fflags_o), .fflags_clr_i(fflags_clr_i),
    .pending_o(pending_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard comparison
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive_res(input logic v, input logic [5:0] tag, input logic [31:0] d,
                           input logic [4:0] st);
    res_valid_i  = v;
    res_tag_i    = tag;
    res_data_i   = d;
    res_status_i = st;
  endtask

  task automatic drive_issue(input logic v, input logic [5:0] tag);
    issue_valid_i = v;
    issue_tag_i   = tag;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, res_ready_o, 1);
    check({tag, "_fwe"},   fwb_we_o, 0);
    check({tag, "_faddr"}, fwb_addr_o, 0);
    check({tag, "_fdata"}, fwb_data_o, 0);
    check({tag, "_ival"},  iwb_valid_o, 0);
    check({tag, "_iaddr"}, iwb_addr_o, 0);
    check({tag, "_idata"}, iwb_data_o, 0);
    check({tag, "_flags"}, fflags_o, 0);
    check({tag, "_pend"},  pending_o, 0);
  endtask

  initial begin
    logic         head_ok, h_int, e_pop, e_ready, e_fwe, e_ival, iss_int;
    logic [W-1:0] head;
    logic [4:0]   rd;

    rst_i = 1'b1; flush_i = 1'b0; iwb_ready_i = 1'b0; fflags_clr_i = 1'b0;
    drive_issue(0, 0);
    drive_res(0, 0, 0, 0);
    tick(); tick();
    check_idle_outputs("reset");
    rst_i = 1'b0;
    tick();

    // 1: FP result retires one cycle after accept, pending set then cleared
    drive_issue(1, 6'h05);
    tick();
    drive_issue(0, 0);
    drive_res(1, 6'h05, 32'h3F80_0000, 5'h00);
    #3;
    check("t1_pend_set", pending_o[5], 1);
    check("t1_no_early", fwb_we_o, 0);
    check("t1_ready", res_ready_o, 1);
    tick();
    drive_res(0, 0, 0, 0);
    #3;
    check("t1_fwe", fwb_we_o, 1);
    check("t1_faddr", fwb_addr_o, 5);
    check("t1_fdata", fwb_data_o, 32'h3F80_0000);
    check("t1_pend_hold", pending_o[5], 1);
    tick();
    #3;
    check("t1_pend_clr", pending_o, 0);
    check("t1_fwe_off", fwb_we_o, 0);
    tick();

    // 2: int result stalls three cycles, following FP result waits behind it
    drive_res(1, 6'h2A, 32'h7, 5'h00);
    tick();
    drive_res(1, 6'h03, 32'hAA, 5'h00);
    for (int i = 0; i < 3; i++) begin
      #3;
      check("t2_ival", iwb_valid_o, 1);
      check("t2_iaddr", iwb_addr_o, 10);
      check("t2_idata", iwb_data_o, 7);
      check("t2_fwe_blocked", fwb_we_o, 0);
      tick();
      drive_res(0, 0, 0, 0);
    end
    iwb_ready_i = 1'b1;
    #3;
    check("t2_ival_pop", iwb_valid_o, 1);
    check("t2_fwe_pop", fwb_we_o, 0);
    tick();
    iwb_ready_i = 1'b0;
    #3;
    check("t2_ival_done", iwb_valid_o, 0);
    check("t2_fwe", fwb_we_o, 1);
    check("t2_faddr", fwb_addr_o, 3);
    check("t2_fdata", fwb_data_o, 32'hAA);
    tick();
    #3;
    check("t2_empty", fwb_we_o, 0);
    tick();

    // 3: fill behind a stalled int head; fifth accepted when ready rises
    for (int i = 0; i < 4; i++) begin
      drive_res(1, (i == 0) ? 6'h21 : 6'(i + 1), 32'((i + 1) * 32'h11), 5'h00);
      #3;
      check("t3_accept", res_ready_o, 1);
      tick();
    end
    drive_res(1, 6'h05, 32'h55, 5'h00);
    #3;
    check("t3_full", res_ready_o, 0);
    tick();
    #3;
    check("t3_full_hold", res_ready_o, 0);
    iwb_ready_i = 1'b1;
    #3;
    check("t3_ready_on_pop", res_ready_o, 1);
    check("t3_iaddr", iwb_addr_o, 1);
    check("t3_idata", iwb_data_o, 32'h11);
    tick();
    drive_res(0, 0, 0, 0);
    iwb_ready_i = 1'b0;
    for (int i = 1; i < 5; i++) begin
      #3;
      check("t3_fwe", fwb_we_o, 1);
      check("t3_faddr", fwb_addr_o, 5'(i + 1));
      check("t3_fdata", fwb_data_o, 32'((i + 1) * 32'h11));
      tick();
    end
    #3;
    check("t3_drained", fwb_we_o, 0);
    tick();

    // 4: sticky flags, then clear coinciding with a pop
    drive_res(1, 6'h06, 32'h1, 5'h01);
    tick();
    drive_res(1, 6'h07, 32'h2, 5'h10);
    tick();
    drive_res(0, 0, 0, 0);
    tick();
    #3;
    check("t4_sticky", fflags_o, 5'h11);
    drive_res(1, 6'h08, 32'h3, 5'h04);
    tick();
    drive_res(0, 0, 0, 0);
    fflags_clr_i = 1'b1;
    #3;
    check("t4_pop", fwb_we_o, 1);
    tick();
    fflags_clr_i = 1'b0;
    #3;
    check("t4_clr_pop", fflags_o, 5'h04);
    tick();

    // 5: flush with three entries and pending 0x70
    drive_issue(1, 6'h04); drive_res(1, 6'h29, 32'h9, 5'h00);
    tick();
    drive_issue(1, 6'h05); drive_res(1, 6'h04, 32'h44, 5'h02);
    tick();
    drive_issue(1, 6'h06); drive_res(1, 6'h05, 32'h45, 5'h02);
    tick();
    drive_issue(0, 0); drive_res(0, 0, 0, 0);
    #3;
    check("t5_pend", pending_o, 32'h0000_0070);
    check("t5_head", iwb_addr_o, 9);
    flush_i = 1'b1; iwb_ready_i = 1'b1;
    drive_res(1, 6'h07, 32'h77, 5'h08);
    #1;
    check("t5_no_iwb", iwb_valid_o, 0);
    check("t5_no_fwe", fwb_we_o, 0);
    tick();
    flush_i = 1'b0; iwb_ready_i = 1'b0;
    drive_res(0, 0, 0, 0);
    #3;
    check("t5_pend_clr", pending_o, 0);
    check("t5_fwe", fwb_we_o, 0);
    check("t5_ival", iwb_valid_o, 0);
    check("t5_flags_kept", fflags_o, 5'h04);
    tick();
    #3;
    check("t5_push_dropped", fwb_we_o, 0);
    tick();

    // 6: asynchronous reset while full
    drive_issue(1, 6'h0C);
    for (int i = 0; i < 4; i++) begin
      drive_res(1, 6'h21, 32'(i), 5'h01);
      tick();
      drive_issue(0, 0);
    end
    drive_res(0, 0, 0, 0);
    #1;
    check("t6_full", res_ready_o, 0);
    check("t6_pend", pending_o, 32'h0000_1000);
    rst_i = 1'b1;
    #1;
    check_idle_outputs("t6_rst");
    tick();
    rst_i = 1'b0;
    tick();

    // randomized traffic against the queue model
    m_pend  = '0;
    m_flags = '0;
    exp_q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      drive_res($urandom_range(0, 99) < 60, {1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31))},
                $urandom, 5'($urandom_range(0, 31)));
      iwb_ready_i  = $urandom_range(0, 99) < 50;
      flush_i      = $urandom_range(0, 99) < 3;
      fflags_clr_i = $urandom_range(0, 99) < 5;
      rd           = 5'($urandom_range(0, 31));
      iss_int      = $urandom_range(0, 3) == 0;
      drive_issue(($urandom_range(0, 99) < 30) && (iss_int || !m_pend[rd]), {iss_int, rd});
      #3;

      head_ok = !flush_i && (exp_q.size() > 0);
      head    = head_ok ? exp_q[0] : '0;
      h_int   = head[5];
      e_fwe   = head_ok && !h_int;
      e_ival  = head_ok && h_int;
      e_pop   = head_ok && (!h_int || iwb_ready_i);
      e_ready = (exp_q.size() < 4) || e_pop;

      check("rnd_fwe", fwb_we_o, e_fwe);
      check("rnd_faddr", fwb_addr_o, e_fwe ? head[4:0] : 5'd0);
      check("rnd_fdata", fwb_data_o, e_fwe ? head[42:11] : 32'd0);
      check("rnd_ival", iwb_valid_o, e_ival);
      check("rnd_iaddr", iwb_addr_o, e_ival ? head[4:0] : 5'd0);
      check("rnd_idata", iwb_data_o, e_ival ? head[42:11] : 32'd0);
      check("rnd_ready", res_ready_o, e_ready);
      check("rnd_flags", fflags_o, m_flags);
      check("rnd_pend", pending_o, m_pend);

      if (fflags_clr_i)  m_flags = e_pop ? head[10:6] : 5'd0;
      else if (e_pop)    m_flags = m_flags | head[10:6];
      if (flush_i) begin
        exp_q.delete();
        m_pend = '0;
      end else begin
        if (e_pop) begin
          void'(exp_q.pop_front());
          if (!h_int) m_pend[head[4:0]] = 1'b0;
        end
        if (res_valid_i && e_ready) exp_q.push_back({res_data_i, res_status_i, res_tag_i});
        if (issue_valid_i && !issue_tag_i[5]) m_pend[issue_tag_i[4:0]] = 1'b1;
      end
      tick();
    end

    drive_res(0, 0, 0, 0);
    drive_issue(0, 0);
    flush_i = 1'b0; fflags_clr_i = 1'b0; iwb_ready_i = 1'b0;
    tick();

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
